// File: rtl/uart_tx_sched_if.sv
// Bus-side and sender-side signals of the UART transmit scheduler.
// The slave modport is the scheduler; the master modport is the bus decode / sender side.
interface uart_tx_sched_if #(
  parameter int DEPTH = 8
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          wr_valid;
  logic [7:0]    wr_data;
  logic          wr_ready;
  logic          flush;
  logic          tx_status;
  logic          tx_en;
  logic [7:0]    tx_data;
  logic          busy;
  logic [LW-1:0] level;
  logic          overflow;
  logic          timeout;
  logic          err_clr;

  modport slave (
    input  wr_valid, wr_data, flush, tx_status, err_clr,
    output wr_ready, tx_en, tx_data, busy, level, overflow, timeout
  );

  modport master (
    output wr_valid, wr_data, flush, tx_status, err_clr,
    input  wr_ready, tx_en, tx_data, busy, level, overflow, timeout
  );
endinterface

// File: rtl/uart_tx_sched.sv
// UART transmit scheduler: byte FIFO feeding a slow sender with a stretched tx_en strobe.
// Define UART_TX_SCHED_WATCHDOG_EN to enable the busy-handshake watchdog and the timeout flag.
module uart_tx_sched #(
  parameter int DEPTH        = 8,
  parameter int EN_PULSE     = 325,
  parameter int BUSY_TIMEOUT = 1024
) (
  input logic             clk,
  input logic             reset,
  uart_tx_sched_if.slave  bus
);
  localparam int PW   = $clog2(DEPTH);
  localparam int LW   = PW + 1;
  localparam int CMAX = (EN_PULSE > BUSY_TIMEOUT) ? EN_PULSE : BUSY_TIMEOUT;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {IDLE, PULSE, WAIT} state_t;

  state_t        state, state_nx;
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level_q, level_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          seen_busy, seen_busy_nx;
  logic          tx_en_q, tx_en_nx;
  logic [7:0]    tx_data_q;
  logic          wr_ready_q, overflow_q;
  logic          push, drop, pop;

  // A flush swallows a same-cycle push silently; only a full FIFO counts as overflow.
  assign push = bus.wr_valid &&  wr_ready_q && !bus.flush;
  assign drop = bus.wr_valid && !wr_ready_q && !bus.flush;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (level_q != '0 && bus.tx_status && !bus.flush) state_nx = PULSE;
      PULSE: if (cnt == CW'(EN_PULSE - 1)) state_nx = WAIT;
      WAIT: begin
        if (seen_busy && bus.tx_status) state_nx = IDLE;
`ifdef UART_TX_SCHED_WATCHDOG_EN
        else if (!seen_busy && cnt == CW'(BUSY_TIMEOUT - 1)) state_nx = IDLE;
`endif
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    pop          = 1'b0;
    tx_en_nx     = tx_en_q;
    cnt_nx       = cnt;
    seen_busy_nx = seen_busy;
    unique case (state)
      IDLE: begin
        if (state_nx == PULSE) begin
          pop          = 1'b1;
          tx_en_nx     = 1'b1;
          cnt_nx       = '0;
          seen_busy_nx = 1'b0;
        end
      end
      PULSE: begin
        if (!bus.tx_status) seen_busy_nx = 1'b1;
        if (cnt == CW'(EN_PULSE - 1)) begin
          tx_en_nx = 1'b0;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      WAIT: begin
        if (!bus.tx_status) seen_busy_nx = 1'b1;
`ifdef UART_TX_SCHED_WATCHDOG_EN
        // Once busy has been seen the watchdog is moot, so the counter stops and cannot wrap.
        if (!seen_busy) cnt_nx = cnt + 1'b1;
`endif
      end
      default: ;
    endcase
  end

  always_comb begin
    level_nx = level_q;
    if (bus.flush)          level_nx = '0;
    else if (push && !pop)  level_nx = level_q + 1'b1;
    else if (pop && !push)  level_nx = level_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      seen_busy  <= 1'b0;
      tx_en_q    <= 1'b0;
      tx_data_q  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_q    <= '0;
      wr_ready_q <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      cnt        <= cnt_nx;
      seen_busy  <= seen_busy_nx;
      tx_en_q    <= tx_en_nx;
      if (pop) tx_data_q <= mem[rd_ptr];
      if (bus.flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
      level_q    <= level_nx;
      wr_ready_q <= (level_nx != LW'(DEPTH));
      if (bus.err_clr)  overflow_q <= 1'b0;
      else if (drop)    overflow_q <= 1'b1;
    end
  end

`ifdef UART_TX_SCHED_WATCHDOG_EN
  logic timeout_q;
  always_ff @(posedge clk) begin
    if (reset)                                                            timeout_q <= 1'b0;
    else if (bus.err_clr)                                                 timeout_q <= 1'b0;
    else if (state == WAIT && !seen_busy && cnt == CW'(BUSY_TIMEOUT - 1)) timeout_q <= 1'b1;
  end
  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

  assign bus.wr_ready = wr_ready_q;
  assign bus.tx_en    = tx_en_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.level    = level_q;
  assign bus.overflow = overflow_q;
  assign bus.busy     = (state != IDLE) || (level_q != '0);
endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: stimulus queues expected bytes, a monitor checks each tx_en pulse.
module tb_uart_tx_sched;
  localparam int DEPTH        = 8;
  localparam int EN_PULSE     = 4;
  localparam int BUSY_TIMEOUT = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  uart_tx_sched_if #(.DEPTH(DEPTH)) bus ();

  uart_tx_sched #(
    .DEPTH(DEPTH), .EN_PULSE(EN_PULSE), .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_q [$];

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: one scoreboard pop per tx_en rise, width and stability checked on the fall.
  logic       prev_en  = 1'b0;
  int         width    = 0;
  logic [7:0] cur      = '0;
  logic       unstable = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      prev_en = 1'b0;
      width   = 0;
    end else begin
      if (bus.tx_en) begin
        if (!prev_en) begin
          width    = 0;
          unstable = 1'b0;
          cur      = bus.tx_data;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_tx_en actual=%0h required=none", bus.tx_data);
          end else begin
            chk("tx_data", bus.tx_data, exp_q.pop_front());
          end
        end else if (bus.tx_data != cur) begin
          unstable = 1'b1;
        end
        width++;
      end else if (prev_en) begin
        chk("pulse_width", width, EN_PULSE);
        chk("tx_data_stable", unstable, 0);
      end
      prev_en = bus.tx_en;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] d, input bit sent);
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    if (sent) exp_q.push_back(d);
    tick();
    bus.wr_valid = 1'b0;
  endtask

  task automatic wait_en(input logic v);
    int n = 0;
    while (bus.tx_en !== v && n < 100) begin
      tick();
      n++;
    end
    chk(v ? "wait_tx_en_rise" : "wait_tx_en_fall", int'(bus.tx_en), int'(v));
  endtask

  // Sender model: take the strobe, report busy for a few cycles, then go idle again.
  task automatic serve(input int n);
    bus.tx_status = 1'b1;
    for (int i = 0; i < n; i++) begin
      wait_en(1'b1);
      wait_en(1'b0);
      bus.tx_status = 1'b0;
      repeat (3) tick();
      bus.tx_status = 1'b1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int k;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    bus.flush     = 1'b0;
    bus.tx_status = 1'b1;
    bus.err_clr   = 1'b0;
    repeat (2) tick();
    reset = 1'b0;

    chk("rst_tx_en",    bus.tx_en,    0);
    chk("rst_tx_data",  bus.tx_data,  0);
    chk("rst_wr_ready", bus.wr_ready, 1);
    chk("rst_level",    bus.level,    0);
    chk("rst_busy",     bus.busy,     0);
    chk("rst_overflow", bus.overflow, 0);
    chk("rst_timeout",  bus.timeout,  0);

    // Single byte
    push_byte(8'h55, 1'b1);
    chk("single_level", bus.level, 1);
    wait_en(1'b1);
    wait_en(1'b0);
    bus.tx_status = 1'b0;
    repeat (10) tick();
    bus.tx_status = 1'b1;
    tick();
    chk("single_busy_after", bus.busy, 0);

    // Fill and overflow
    bus.tx_status = 1'b0;
    for (int i = 1; i <= 9; i++) push_byte(8'(i), i <= 8);
    chk("fill_level",    bus.level,    8);
    chk("fill_wr_ready", bus.wr_ready, 0);
    chk("fill_overflow", bus.overflow, 1);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    chk("fill_err_clr", bus.overflow, 0);
    serve(8);
    tick();
    chk("drain_level", bus.level, 0);
    chk("drain_busy",  bus.busy,  0);

    // Flush during send
    bus.tx_status = 1'b1;
    push_byte(8'hA0, 1'b1);
    push_byte(8'hA1, 1'b0);
    push_byte(8'hA2, 1'b0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush_level",    bus.level, 0);
    chk("flush_inflight", bus.tx_en, 1);
    serve(1);
    repeat (20) tick();
    chk("flush_busy", bus.busy, 0);

    // Simultaneous push/pop while full, then err_clr against a full-push
    bus.tx_status = 1'b0;
    for (int i = 0; i < 8; i++) push_byte(8'hB0 + 8'(i), 1'b1);
    chk("sim_full_level", bus.level, 8);
    bus.tx_status = 1'b1;
    bus.wr_valid  = 1'b1;
    bus.wr_data   = 8'hEE;
    tick();
    bus.wr_valid = 1'b0;
    chk("sim_overflow", bus.overflow, 1);
    chk("sim_level",    bus.level,    7);
    push_byte(8'hB8, 1'b1);
    chk("sim_refill_level", bus.level,    8);
    chk("sim_wr_ready",     bus.wr_ready, 0);
    bus.err_clr  = 1'b1;
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'hEF;
    tick();
    bus.err_clr  = 1'b0;
    bus.wr_valid = 1'b0;
    chk("sim_clr_priority", bus.overflow, 0);
    chk("sim_clr_level",    bus.level,    8);
    serve(9);

    // Watchdog: sender never reports busy
    bus.tx_status = 1'b1;
    push_byte(8'h33, 1'b1);
    push_byte(8'h34, 1'b1);
    wait_en(1'b1);
    wait_en(1'b0);
    k = 0;
    while (!bus.timeout && k < 40) begin
      tick();
      k++;
    end
`ifdef UART_TX_SCHED_WATCHDOG_EN
    chk("wd_delay",   k,           BUSY_TIMEOUT);
    chk("wd_timeout", bus.timeout, 1);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    chk("wd_timeout_clr", bus.timeout, 0);
    serve(1);
`else
    chk("nowd_timeout", bus.timeout, 0);
    chk("nowd_busy",    bus.busy,    1);
    chk("nowd_tx_en",   bus.tx_en,   0);
    bus.tx_status = 1'b0;
    repeat (3) tick();
    serve(1);
`endif
    repeat (3) tick();

    // Reset mid-pulse with bytes still queued
    bus.tx_status = 1'b0;
    push_byte(8'hC0, 1'b1);
    push_byte(8'hC1, 1'b0);
    push_byte(8'hC2, 1'b0);
    push_byte(8'hC3, 1'b0);
    bus.tx_status = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstmid_tx_en",    bus.tx_en,    0);
    chk("rstmid_level",    bus.level,    0);
    chk("rstmid_wr_ready", bus.wr_ready, 1);
    chk("rstmid_busy",     bus.busy,     0);
    repeat (20) tick();

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
